wb_stage: RTL



---
 rtl/wb_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage. Registers the execute-stage result, control
// word and instruction, collects load data from data memory via a ready
// strobe, and drives the register-file write port.
//
// Ports:
//   clk          in   system clock
//   sync_rst     in   synchronous reset, active-high
//   clk_en       in   pipeline advance (already qualified with !stall upstream)
//   ctr_word_in  in   [0] wr_en, [1] src_mem, [3:2] rd_sel, [4] halt
//   inst_bus     in   instruction word from execute
//   alu_res      in   execute ALU result
//   mem_rdata    in   data-memory read data, valid while mem_ready=1
//   mem_ready    in   data-memory read-data-valid strobe
//   reg_we       out  register-file write enable
//   rd_addr      out  destination register
//   write_in     out  write data
//   stall        out  hold the whole pipeline while a load is outstanding
//   halted       out  sticky halt
//   mem_err      out  sticky load-timeout flag
module wb_stage #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        sync_rst,
   input  logic        clk_en,
   input  logic [4:0]  ctr_word_in,
   input  logic [15:0] inst_bus,
   input  logic [7:0]  alu_res,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        reg_we,
   output logic [3:0]  rd_addr,
   output logic [7:0]  write_in,
   output logic        stall,
   output logic        halted,
   output logic        mem_err
);

   localparam int unsigned CTR_W  = 5;
   localparam int unsigned INST_W = 12;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HELD = 2'd2
   } state_e;

   // Pipeline register; inst[15:12] is never decoded so it is not stored.
   logic [CTR_W-1:0]  ctr_q;
   logic [INST_W-1:0] inst_q;
   logic [DATA_W-1:0] alu_q;

   logic unused_inst;
   assign unused_inst = ^inst_bus[15:12];

   // Load FSM and supporting state
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              halted_q, halted_d;
   logic              mem_err_q, mem_err_d;

   logic              stall_c;
   logic              err_set_c;
   logic [DATA_W-1:0] ld_data_c;
   logic              is_load_c;
   logic [1:0]        rd_sel_c;

   assign is_load_c = ctr_q[1] & ctr_q[0];
   assign rd_sel_c  = ctr_q[3:2];

   // Pipeline register: reset wins regardless of clk_en
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         ctr_q  <= '0;
         inst_q <= '0;
         alu_q  <= '0;
      end else if (clk_en) begin
         ctr_q  <= ctr_word_in;
         inst_q <= inst_bus[INST_W-1:0];
         alu_q  <= alu_res;
      end
   end

   // FSM, counter, hold and sticky flag registers
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         halted_q  <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         halted_q  <= halted_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Load FSM next-state and stall. stall never looks at clk_en, which keeps
   // the upstream clk_en = run & !stall path free of combinational loops.
   // A load that completes on an edge where the pipeline advances has already
   // retired, so it returns to IDLE instead of parking in HELD.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      stall_c   = 1'b0;
      err_set_c = 1'b0;
      ld_data_c = hold_q;
      case (state_q)
         S_IDLE: begin
            if (is_load_c) begin
               if (mem_ready) begin
                  ld_data_c = mem_rdata;
                  if (!clk_en) begin
                     hold_d  = mem_rdata;
                     state_d = S_HELD;
                  end
               end else begin
                  stall_c = 1'b1;
                  cnt_d   = CNT_W'(1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               ld_data_c = mem_rdata;
               hold_d    = mem_rdata;
               cnt_d     = '0;
               state_d   = clk_en ? S_IDLE : S_HELD;
            end else if (cnt_q >= CNT_W'(MEM_TIMEOUT)) begin
               // Abandon the load: write zero and flag the error
               ld_data_c = '0;
               hold_d    = '0;
               err_set_c = 1'b1;
               cnt_d     = '0;
               state_d   = clk_en ? S_IDLE : S_HELD;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_HELD: begin
            ld_data_c = hold_q;
            if (clk_en) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sticky flags: halt is recorded only when the halting instruction retires
   always_comb begin
      halted_d  = halted_q | (ctr_q[4] & clk_en & ~stall_c);
      mem_err_d = mem_err_q | err_set_c;
   end

   // Destination decode; rd_sel=11 means no write
   always_comb begin
      rd_addr = '0;
      case (rd_sel_c)
         2'b00:   rd_addr = inst_q[3:0];
         2'b01:   rd_addr = inst_q[11:8];
         2'b10:   rd_addr = inst_q[7:4];
         default: rd_addr = ADDR_W'(0);
      endcase
   end

   assign write_in = is_load_c ? ld_data_c : alu_q;
   assign reg_we   = ctr_q[0] & (rd_sel_c != 2'b11) & ~stall_c & ~sync_rst;
   assign stall    = stall_c;
   assign halted   = halted_q;
   assign mem_err  = mem_err_q;

endmodule
